// File: rtl/key_scan.sv
// 4x4 active-low key matrix scanner: column drive, row sampling, frame-level
// debounce of single presses, and a valid/ready key-code output.
module key_scan #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_out,
  input  logic [3:0] row_in,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_lost
);

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HELD, S_RELEASE} state_t;

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB        = 4'(DEBOUNCE);

  function automatic logic [3:0] key_index(input logic [15:0] f);
    key_index = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (f[i]) key_index = 4'(i);
    end
  endfunction

  function automatic logic is_single(input logic [15:0] f);
    is_single = (f != 16'h0) && ((f & (f - 16'd1)) == 16'h0);
  endfunction

  logic [3:0]  row_p0, row_p1;
  logic [15:0] dwell;
  logic [1:0]  col;
  logic [15:0] snap;
  state_t      state, state_nxt;
  logic [3:0]  dbc, dbc_nxt, dbc_inc;
  logic [3:0]  cand, cand_nxt;
  logic        held_entry;
  logic        key_valid_nxt, key_lost_nxt;
  logic [3:0]  key_code_nxt;

  // ---- stage p0/p1: row synchronizer (rows idle high) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= row_in;
      row_p1 <= row_p0;
    end
  end

  logic        dwell_last, frame_end, frame_none, frame_single;
  logic [3:0]  hits, frame_key;
  logic [15:0] frame;

  assign dwell_last   = (dwell == DWELL_LAST);
  assign frame_end    = dwell_last && (col == 2'd3);
  assign hits         = ~row_p1;
  // The column-3 slice is still in flight at frame end, so splice it in live.
  assign frame        = {hits, snap[11:0]};
  assign frame_none   = (frame == 16'h0);
  assign frame_single = is_single(frame);
  assign frame_key    = key_index(frame);
  assign dbc_inc      = dbc + 4'd1;

  // ---- column scan and frame snapshot ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell   <= 16'h0;
      col     <= 2'd0;
      col_out <= 4'b1110;
      snap    <= 16'h0;
    end else begin
      dwell <= dwell_last ? 16'h0 : dwell + 16'd1;
      if (dwell_last) begin
        col                     <= col + 2'd1;
        col_out                 <= ~(4'b0001 << (col + 2'd1));
        snap[{col, 2'b00} +: 4] <= hits;
      end
    end
  end

  // ---- debounce FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      dbc   <= 4'h0;
      cand  <= 4'h0;
    end else begin
      state <= state_nxt;
      dbc   <= dbc_nxt;
      cand  <= cand_nxt;
    end
  end

  // ---- debounce FSM: next state ----
  always_comb begin
    state_nxt  = state;
    dbc_nxt    = dbc;
    cand_nxt   = cand;
    held_entry = 1'b0;
    if (frame_end) begin
      case (state)
        S_IDLE: begin
          if (frame_single) begin
            cand_nxt = frame_key;
            dbc_nxt  = 4'd1;
            if (DEB == 4'd1) begin
              state_nxt  = S_HELD;
              held_entry = 1'b1;
            end else begin
              state_nxt = S_CONFIRM;
            end
          end
        end
        S_CONFIRM: begin
          if (frame_single && frame_key == cand) begin
            dbc_nxt = dbc_inc;
            if (dbc_inc == DEB) begin
              state_nxt  = S_HELD;
              held_entry = 1'b1;
            end
          end else if (frame_single) begin
            cand_nxt = frame_key;
            dbc_nxt  = 4'd1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_HELD: begin
          if (frame_none) begin
            dbc_nxt   = 4'd1;
            state_nxt = (DEB == 4'd1) ? S_IDLE : S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (frame_none) begin
            dbc_nxt = dbc_inc;
            if (dbc_inc == DEB) state_nxt = S_IDLE;
          end else begin
            state_nxt = S_HELD;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---- debounce FSM: outputs (handshake next values) ----
  always_comb begin
    key_valid_nxt = key_valid;
    key_code_nxt  = key_code;
    key_lost_nxt  = 1'b0;
    if (held_entry) begin
      // A same-cycle acceptance frees the slot, so the new press is not lost.
      if (!key_valid || key_ready) begin
        key_valid_nxt = 1'b1;
        key_code_nxt  = cand;
      end else begin
        key_lost_nxt = 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_lost  <= 1'b0;
    end else begin
      key_valid <= key_valid_nxt;
      key_code  <= key_code_nxt;
      key_lost  <= key_lost_nxt;
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Randomized scoreboard bench for key_scan with a keypad model and a
// frame-history reference model of the debounce and handshake rules.
module tb_key_scan;
  localparam int SD = 8;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_out, row_in, key_code;
  logic       key_valid, key_ready, key_lost;

  key_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .col_out(col_out), .row_in(row_in),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .key_lost(key_lost)
  );

  always #5 clk = ~clk;

  // Keypad: bit c*4+r pressed shorts row r to column c.
  logic [15:0] pressed;
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_out[c] && pressed[c*4+r]) row_in[r] = 1'b0;
  end

  int          compared = 0, mismatched = 0;
  int          e, col_m;
  logic        valid_m, lost_m, accept_m, rpt_m, latched, all_none, all_same;
  logic [3:0]  code_m, rk_m;
  logic [15:0] cur;
  logic [15:0] hist[$];
  logic [3:0]  exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press is reported when the last DB frames are all the
  // same single key and the previous press has seen DB all-empty frames.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      e = 0; col_m = 0; valid_m = 0; lost_m = 0; code_m = 0; cur = 0;
      latched = 0; hist.delete(); exp_q.delete();
    end else begin
      rpt_m = 0; rk_m = 0; lost_m = 0;
      accept_m = valid_m && key_ready;
      if (e % SD == SD - 1) begin
        cur[col_m*4 +: 4] = pressed[col_m*4 +: 4];
        if (col_m == 3) begin
          hist.push_back(cur);
          if (hist.size() > DB) void'(hist.pop_front());
          if (hist.size() == DB) begin
            all_none = 1; all_same = $onehot(hist[0]);
            foreach (hist[i]) begin
              if (hist[i] != 0) all_none = 0;
              if (hist[i] != hist[0]) all_same = 0;
            end
            if (!latched && all_same) begin
              rpt_m = 1; latched = 1;
              for (int b = 0; b < 16; b++) if (hist[0][b]) rk_m = 4'(b);
            end else if (latched && all_none) begin
              latched = 0;
            end
          end
        end
        col_m = (col_m + 1) % 4;
      end
      if (rpt_m) begin
        if (!valid_m || accept_m) begin
          valid_m = 1; code_m = rk_m; exp_q.push_back(rk_m);
        end else begin
          lost_m = 1;
        end
      end else if (accept_m) begin
        valid_m = 0;
      end
      e++;
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on each acceptance.
  logic [3:0] exp_col, exp_code;
  initial forever begin
    @(negedge clk); #1;
    if (rst) begin
      chk("rst_col_out", 16'(col_out), 16'h000E);
      chk("rst_key_valid", 16'(key_valid), 16'h0);
      chk("rst_key_code", 16'(key_code), 16'h0);
      chk("rst_key_lost", 16'(key_lost), 16'h0);
    end else begin
      exp_col = ~(4'b0001 << col_m);
      chk("col_out", 16'(col_out), 16'(exp_col));
      chk("key_valid", 16'(key_valid), 16'(valid_m));
      chk("key_lost", 16'(key_lost), 16'(lost_m));
      chk("key_code", 16'(key_code), 16'(code_m));
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_key", 16'(key_code), 16'hFFFF);
        end else begin
          exp_code = exp_q.pop_front();
          chk("accepted_code", 16'(key_code), 16'(exp_code));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Change keys only early in a dwell so every sample sees a settled level.
  task automatic set_keys(input logic [15:0] m);
    @(negedge clk);
    while ((e % SD) >= 4) @(negedge clk);
    pressed = m;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    cyc(n);
    rst = 1'b0;
  endtask

  int          r;
  logic [15:0] m;
  initial begin
    rst = 1'b1; pressed = 16'h0; key_ready = 1'b1;
    repeat (6) begin @(negedge clk); pressed = 16'($urandom); end
    @(negedge clk); pressed = 16'h0; rst = 1'b0;
    cyc(40);
    // clean press of column 1 row 2
    set_keys(16'h0040); cyc(320); set_keys(16'h0); cyc(160);
    // bounce then stable, then two keys at once
    for (int i = 0; i < 8; i++) begin
      set_keys((i % 2) ? 16'h0 : 16'h0800); cyc(20);
    end
    set_keys(16'h0800); cyc(192); set_keys(16'h0); cyc(160);
    set_keys(16'h0208); cyc(192); set_keys(16'h0); cyc(160);
    // backpressure and lost press
    key_ready = 1'b0;
    set_keys(16'h0001); cyc(160); set_keys(16'h0); cyc(160);
    set_keys(16'h8000); cyc(160); set_keys(16'h0); cyc(160);
    @(negedge clk); key_ready = 1'b1;
    @(negedge clk); key_ready = 1'b0;
    cyc(10); key_ready = 1'b1;
    // short and long release gaps
    set_keys(16'h0020); cyc(160); set_keys(16'h0); cyc(64);
    set_keys(16'h0020); cyc(160); set_keys(16'h0); cyc(160);
    set_keys(16'h0020); cyc(160); set_keys(16'h0); cyc(160);
    // reset during confirm and while a key is pending
    key_ready = 1'b0;
    set_keys(16'h0200); cyc(48); do_reset(3); cyc(160);
    do_reset(2); cyc(160);
    key_ready = 1'b1; set_keys(16'h0); cyc(160);
    // random keys and backpressure
    repeat (30) begin
      r = $urandom_range(0, 9);
      if (r < 6)      m = 16'(1 << $urandom_range(0, 15));
      else if (r < 8) m = 16'h0;
      else            m = 16'($urandom);
      set_keys(m);
      key_ready = 1'($urandom_range(0, 1));
      cyc($urandom_range(10, 150));
    end
    key_ready = 1'b1; set_keys(16'h0); cyc(200);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
